fp_mul_exp_pack: RTL and testbench

- Downstream stage of the mantissa multiplier in the floating-point multiply path.
- Accepts the two original operands plus the rounded product fraction and normalisation carry from the mantissa multiplier.
- Computes result sign and exponent, classifies special cases, and packs an IEEE-754-style word.
- Two-stage valid/ready pipeline; the output feeds the FPU result bus.

---
 rtl/fp_mul_exp_pack.sv | 152 +++++++++++++++
 tb/tb_fp_mul_exp_pack.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/fp_mul_exp_pack.sv
// Sign/exponent/special-case stage after the mantissa multiplier: classifies operands,
// forms the biased exponent sum and packs the IEEE-754-style product over two pipeline stages.
module fp_mul_exp_pack #(
  parameter int EXP_WIDTH = 8,
  parameter int BIT_WIDTH = 23
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [EXP_WIDTH+BIT_WIDTH:0]   in_a,
  input  logic [EXP_WIDTH+BIT_WIDTH:0]   in_b,
  input  logic [BIT_WIDTH-1:0]           in_mant,
  input  logic                           in_carry,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [EXP_WIDTH+BIT_WIDTH:0]   out_result,
  output logic                           out_overflow,
  output logic                           out_underflow,
  output logic                           out_invalid
);
  localparam int W  = 1 + EXP_WIDTH + BIT_WIDTH;
  localparam int EW = EXP_WIDTH + 2;
  localparam logic [EW-1:0] BIAS_EXT = EW'((1 << (EXP_WIDTH - 1)) - 1);
  localparam logic [EW-1:0] EMAX_EXT = {2'b00, {EXP_WIDTH{1'b1}}};

  localparam logic [1:0] CLS_NORM = 2'd0;
  localparam logic [1:0] CLS_ZERO = 2'd1;
  localparam logic [1:0] CLS_INF  = 2'd2;
  localparam logic [1:0] CLS_NAN  = 2'd3;

  logic                 s1_valid_reg, s2_valid_reg;
  logic                 s1_ready, s2_ready;
  logic                 s1_sign_reg;
  logic [1:0]           s1_class_reg;
  logic [EW-1:0]        s1_exp_sum_reg;
  logic [BIT_WIDTH-1:0] s1_mant_reg;
  logic [W-1:0]         s2_result_reg;
  logic                 s2_ovf_reg, s2_unf_reg, s2_inv_reg;

  logic                 a_sign, b_sign;
  logic [EXP_WIDTH-1:0] a_exp, b_exp;
  logic [BIT_WIDTH-1:0] a_frac, b_frac;
  logic                 a_max, b_max, a_zero, b_zero, a_nan, b_nan, a_inf, b_inf;
  logic [1:0]           class_next;
  logic [EW-1:0]        exp_sum_next;

  assign s2_ready = !s2_valid_reg || out_ready;
  assign s1_ready = !s1_valid_reg || s2_ready;
  assign in_ready = s1_ready;

  assign a_sign = in_a[W-1];
  assign b_sign = in_b[W-1];
  assign a_exp  = in_a[W-2 -: EXP_WIDTH];
  assign b_exp  = in_b[W-2 -: EXP_WIDTH];
  assign a_frac = in_a[BIT_WIDTH-1:0];
  assign b_frac = in_b[BIT_WIDTH-1:0];

  assign a_max  = &a_exp;
  assign b_max  = &b_exp;
  assign a_zero = ~|a_exp;
  assign b_zero = ~|b_exp;
  assign a_nan  = a_max && (|a_frac);
  assign b_nan  = b_max && (|b_frac);
  assign a_inf  = a_max && !(|a_frac);
  assign b_inf  = b_max && !(|b_frac);

  // Two's-complement sum in EW bits; the two guard bits hold both the overflow and negative ranges.
  assign exp_sum_next = {2'b00, a_exp} + {2'b00, b_exp} - BIAS_EXT + {{(EW-1){1'b0}}, in_carry};

  always_comb begin
    class_next = CLS_NORM;
    if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero))
      class_next = CLS_NAN;
    else if (a_inf || b_inf)
      class_next = CLS_INF;
    else if (a_zero || b_zero)
      class_next = CLS_ZERO;
  end

  logic [W-1:0] result_next;
  logic         ovf_next, unf_next, inv_next;
  logic         exp_big, exp_small;

  assign exp_big   = $signed(s1_exp_sum_reg) >= $signed(EMAX_EXT);
  assign exp_small = s1_exp_sum_reg[EW-1] || (s1_exp_sum_reg == '0);

  always_comb begin
    result_next = {s1_sign_reg, s1_exp_sum_reg[EXP_WIDTH-1:0], s1_mant_reg};
    ovf_next    = 1'b0;
    unf_next    = 1'b0;
    inv_next    = 1'b0;
    case (s1_class_reg)
      CLS_NAN: begin
        result_next = {1'b0, {EXP_WIDTH{1'b1}}, 1'b1, {(BIT_WIDTH-1){1'b0}}};
        inv_next    = 1'b1;
      end
      CLS_INF:  result_next = {s1_sign_reg, {EXP_WIDTH{1'b1}}, {BIT_WIDTH{1'b0}}};
      CLS_ZERO: result_next = {s1_sign_reg, {(W-1){1'b0}}};
      default: begin
        if (exp_big) begin
          result_next = {s1_sign_reg, {EXP_WIDTH{1'b1}}, {BIT_WIDTH{1'b0}}};
          ovf_next    = 1'b1;
        end else if (exp_small) begin
          result_next = {s1_sign_reg, {(W-1){1'b0}}};
          unf_next    = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_reg   <= 1'b0;
      s2_valid_reg   <= 1'b0;
      s1_sign_reg    <= 1'b0;
      s1_class_reg   <= CLS_NORM;
      s1_exp_sum_reg <= '0;
      s1_mant_reg    <= '0;
      s2_result_reg  <= '0;
      s2_ovf_reg     <= 1'b0;
      s2_unf_reg     <= 1'b0;
      s2_inv_reg     <= 1'b0;
    end else begin
      // Each stage loads only when its consumer has room, so held data stays bit-stable.
      if (s1_ready) begin
        s1_valid_reg <= in_valid;
        if (in_valid) begin
          s1_sign_reg    <= a_sign ^ b_sign;
          s1_class_reg   <= class_next;
          s1_exp_sum_reg <= exp_sum_next;
          s1_mant_reg    <= in_mant;
        end
      end
      if (s2_ready) begin
        s2_valid_reg <= s1_valid_reg;
        if (s1_valid_reg) begin
          s2_result_reg <= result_next;
          s2_ovf_reg    <= ovf_next;
          s2_unf_reg    <= unf_next;
          s2_inv_reg    <= inv_next;
        end
      end
    end
  end

  assign out_valid     = s2_valid_reg;
  assign out_result    = s2_result_reg;
  assign out_overflow  = s2_valid_reg && s2_ovf_reg;
  assign out_underflow = s2_valid_reg && s2_unf_reg;
  assign out_invalid   = s2_valid_reg && s2_inv_reg;
endmodule

// File: tb/tb_fp_mul_exp_pack.sv
// Directed bench for fp_mul_exp_pack: a reference model fills a scoreboard on every accepted
// beat and each emitted result is popped and compared in order.
module tb_fp_mul_exp_pack;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [31:0] in_a, in_b;
  logic [22:0] in_mant;
  logic        in_carry;
  logic        out_valid, out_ready;
  logic [31:0] out_result;
  logic        out_overflow, out_underflow, out_invalid;

  int tests = 0;
  int fails = 0;
  logic [34:0] sb[$];

  always #5 clk = ~clk;

  fp_mul_exp_pack #(.EXP_WIDTH(8), .BIT_WIDTH(23)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_mant(in_mant), .in_carry(in_carry),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_overflow(out_overflow), .out_underflow(out_underflow), .out_invalid(out_invalid)
  );

  // Returns {invalid, underflow, overflow, result}.
  function automatic logic [34:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic [22:0] m, input logic c);
    int ea, eb, e;
    logic s, an, bn, ai, bi, az, bz;
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    s  = a[31] ^ b[31];
    an = (ea == 255) && (a[22:0] != 0);
    bn = (eb == 255) && (b[22:0] != 0);
    ai = (ea == 255) && (a[22:0] == 0);
    bi = (eb == 255) && (b[22:0] == 0);
    az = (ea == 0);
    bz = (eb == 0);
    if (an || bn || (ai && bz) || (bi && az)) return {3'b100, 32'h7FC00000};
    if (ai || bi) return {3'b000, s, 8'hFF, 23'd0};
    if (az || bz) return {3'b000, s, 31'd0};
    e = ea + eb - 127 + int'(c);
    if (e >= 255) return {3'b001, s, 8'hFF, 23'd0};
    if (e <= 0) return {3'b010, s, 31'd0};
    return {3'b000, s, e[7:0], m};
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s got=%0h required=%0h", tag, got, exp);
    end
  endtask

  // One clock: scoreboard traffic is observed mid-cycle, then returns 1 time unit after the edge.
  task automatic cycle();
    logic [34:0] exp, got;
    @(negedge clk);
    if (!rst) begin
      if (out_valid && out_ready) begin
        got = {out_invalid, out_underflow, out_overflow, out_result};
        $display("[TB] out result=%h inv=%0b unf=%0b ovf=%0b", out_result, out_invalid,
                 out_underflow, out_overflow);
        if (sb.size() == 0) begin
          check("unexpected_output", {29'd0, got}, 64'h0);
        end else begin
          exp = sb.pop_front();
          check("result", {29'd0, got}, {29'd0, exp});
        end
      end
      if (in_valid && in_ready) begin
        $display("[TB] in  a=%h b=%h mant=%h carry=%0b", in_a, in_b, in_mant, in_carry);
        sb.push_back(model(in_a, in_b, in_mant, in_carry));
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send_one(input logic [31:0] a, input logic [31:0] b,
                          input logic [22:0] m, input logic c);
    int n;
    in_valid = 1'b1; in_a = a; in_b = b; in_mant = m; in_carry = c;
    n = 0;
    while (!in_ready && n < 20) begin
      cycle();
      n++;
    end
    check("accept_timeout", {63'd0, in_ready}, 64'd1);
    cycle();
    in_valid = 1'b0;
    check("latency_1", {63'd0, out_valid}, 64'd0);
    cycle();
    check("latency_2", {63'd0, out_valid}, 64'd1);
    cycle();
  endtask

  logic [31:0] ba[5], bb[5], held;
  logic [22:0] bm[5];
  logic        bc[5];
  int          idx;
  logic        acc;

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_mant = '0; in_carry = 1'b0;
    out_ready = 1'b1;
    cycle();
    cycle();
    rst = 1'b0;
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_out_result", {32'd0, out_result}, 64'd0);
    check("rst_flags", {61'd0, out_invalid, out_underflow, out_overflow}, 64'd0);
    cycle();
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);

    send_one(32'h40400000, 32'h40000000, 23'h400000, 1'b0);
    send_one(32'h3FC00000, 32'h3FC00000, 23'h100000, 1'b1);
    send_one(32'hBFC00000, 32'h3FC00000, 23'h100000, 1'b1);
    send_one(32'h7F000000, 32'h7F000000, 23'h000000, 1'b0);
    send_one(32'h00800000, 32'h00800000, 23'h000000, 1'b0);
    send_one(32'h7F800000, 32'h00000000, 23'h000000, 1'b0);
    send_one(32'hFF800000, 32'h40000000, 23'h000000, 1'b0);
    send_one(32'h80000000, 32'h3F800000, 23'h000000, 1'b0);

    // Backpressure: five back-to-back beats while the consumer stalls, then drains.
    for (int i = 0; i < 5; i++) begin
      ba[i] = {1'($urandom), 8'($urandom_range(100, 154)), 23'($urandom)};
      bb[i] = {1'($urandom), 8'($urandom_range(100, 154)), 23'($urandom)};
      bm[i] = 23'($urandom);
      bc[i] = 1'($urandom);
    end
    idx = 0;
    held = '0;
    for (int c = 0; c < 13; c++) begin
      out_ready = (c >= 6);
      in_valid  = (idx < 5);
      if (idx < 5) begin
        in_a = ba[idx]; in_b = bb[idx]; in_mant = bm[idx]; in_carry = bc[idx];
      end
      #1;
      if (c == 2) held = out_result;
      if (c >= 2 && c <= 5) begin
        check("bp_in_ready_low", {63'd0, in_ready}, 64'd0);
        check("bp_hold_valid", {63'd0, out_valid}, 64'd1);
        check("bp_hold_result", {32'd0, out_result}, {32'd0, held});
      end
      if (c >= 6 && c <= 10) check("bp_no_gap", {63'd0, out_valid}, 64'd1);
      if (c >= 11) check("bp_drained", {63'd0, out_valid}, 64'd0);
      acc = in_valid && in_ready;
      cycle();
      if (acc) idx++;
    end
    in_valid = 1'b0;
    check("bp_all_accepted", 64'(idx), 64'd5);

    // Reset with both stages full: the two held beats must vanish.
    out_ready = 1'b0;
    in_valid = 1'b1; in_a = 32'h40400000; in_b = 32'h40400000; in_mant = 23'h100000; in_carry = 1'b0;
    cycle();
    cycle();
    in_valid = 1'b0;
    check("full_out_valid", {63'd0, out_valid}, 64'd1);
    check("full_in_ready", {63'd0, in_ready}, 64'd0);
    rst = 1'b1;
    sb.delete();
    cycle();
    rst = 1'b0;
    check("mid_rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("mid_rst_in_ready", {63'd0, in_ready}, 64'd1);
    check("mid_rst_out_result", {32'd0, out_result}, 64'd0);
    out_ready = 1'b1;
    repeat (4) cycle();
    check("mid_rst_no_output", {63'd0, out_valid}, 64'd0);

    send_one(32'h40400000, 32'h40000000, 23'h400000, 1'b0);
    check("scoreboard_empty", 64'(sb.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
